// File: rtl/key_mode_sequencer_pkg.sv
// key_mode_sequencer_pkg: shared mode/debouncer encodings and the mode step helper
package key_mode_sequencer_pkg;
  localparam logic [1:0] MODE_ARITH = 2'd0;
  localparam logic [1:0] MODE_LOGIC = 2'd1;
  localparam logic [1:0] MODE_CMP   = 2'd2;
  localparam logic [1:0] MODE_MAGIC = 2'd3;
  localparam logic [1:0] ST_UP     = 2'd0;
  localparam logic [1:0] ST_CNT_DN = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_CNT_UP = 2'd3;
  typedef logic [1:0] mode_t;
  function automatic mode_t mode_step(mode_t m, logic [1:0] evt);
    return evt == 2'b01 ? m + 2'd1 : evt == 2'b10 ? m - 2'd1 : m;
  endfunction
endpackage

// File: rtl/key_mode_sequencer_if.sv
// key_mode_sequencer_if: pushbutton inputs and mode outputs of the sequencer
interface key_mode_sequencer_if;
  import key_mode_sequencer_pkg::*;
  logic [1:0] KEY;
  mode_t      MODE;
  logic       MODE_STROBE;
  logic [1:0] KEY_HELD;
  modport master (output KEY, input MODE, MODE_STROBE, KEY_HELD);
  modport slave (input KEY, output MODE, MODE_STROBE, KEY_HELD);
endinterface

// File: rtl/key_mode_sequencer_debouncer.sv
// key_debouncer: two-flop synchroniser plus counting debounce FSM for one active-low key
module key_debouncer
  import key_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic held,
  output logic press_evt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [1:0] st;
  logic [CNT_W-1:0] cnt;
  logic skey;
  assign skey = sync[1];
  assign held = st == ST_DOWN || st == ST_CNT_UP;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync      <= 2'b11;
      st        <= ST_UP;
      cnt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync      <= {sync[0], key_n};
      press_evt <= 1'b0;
      case (st)
        ST_UP: if (!skey) begin
          st  <= ST_CNT_DN;
          cnt <= CNT_W'(1);
        end
        ST_CNT_DN: if (skey) begin
          st  <= ST_UP;
          cnt <= '0;
        end else if (cnt == LAST) begin
          st        <= ST_DOWN;
          cnt       <= '0;
          press_evt <= 1'b1;
        end else cnt <= cnt + 1'b1;
        ST_DOWN: if (skey) begin
          st  <= ST_CNT_UP;
          cnt <= CNT_W'(1);
        end
        default: if (!skey) begin
          st  <= ST_DOWN;
          cnt <= '0;
        end else if (cnt == LAST) begin
          st  <= ST_UP;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/key_mode_sequencer.sv
// key_mode_sequencer: debounces KEY[1:0] and steps MODE forward/backward with a change strobe
module key_mode_sequencer
  import key_mode_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input logic CLK,
  input logic RST,
  key_mode_sequencer_if.slave bus
);
  logic [1:0] press_evt;
  logic [1:0] held;
  mode_t mode;
  logic strobe;
  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .CLK(CLK),
      .RST(RST),
      .key_n(bus.KEY[i]),
      .held(held[i]),
      .press_evt(press_evt[i])
    );
  end
  // Simultaneous presses cancel, so only a lone event changes MODE
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode   <= MODE_ARITH;
      strobe <= 1'b0;
    end else begin
      mode   <= mode_step(mode, press_evt);
      strobe <= ^press_evt;
    end
  end
  assign bus.MODE        = mode;
  assign bus.MODE_STROBE = strobe;
  assign bus.KEY_HELD    = held;
endmodule
